id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand builder.
- Captures decoded instruction fields from ID each cycle and forwards results from EX/MEM and MEM/WB.
- Builds the ALU operands `data1`/`data2`/`aluc` for the 5-bit-opcode ALU in EX.
- Detects load-use hazards, stalls IF/ID, and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width; register 0 is hard-wired zero and never forwarded.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  turn next EX contents into a bubble (branch/jump redirect)
- id_aluc  in  5  decoded ALU op: 0 nop, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl, 8 sra, 10 addi, 11 andi, 12 ori, 13 xori, 14 lw, 15 sw, 18 lui
- id_rs_addr / id_rt_addr / id_rd_addr  in  REG_AW each  source regs and destination (rd for R-type, rt for I-type; decoder resolves)
- id_rs_val / id_rt_val  in  DATA_W each  register-file read data
- id_imm16  in  16  instruction immediate
- id_shamt  in  5  shift amount
- id_reg_write / id_mem_read / id_mem_write  in  1 each  control
- exm_rd  in  REG_AW  EX/MEM destination
- exm_reg_write  in  1  EX/MEM write enable
- exm_result  in  DATA_W  EX/MEM ALU result
- mwb_rd  in  REG_AW  MEM/WB destination
- mwb_reg_write  in  1  MEM/WB write enable
- mwb_result  in  DATA_W  MEM/WB writeback data
- load_use_stall  out  1  hold PC and IF/ID this cycle (combinational)
- alu_data1 / alu_data2  out  DATA_W each  ALU operands (combinational from registered state)
- alu_aluc  out  5  registered op
- ex_store_data  out  DATA_W  forwarded rt for sw
- ex_rd  out  REG_AW  registered destination
- ex_reg_write / ex_mem_read / ex_mem_write  out  1 each  registered control

Behaviour:
- **Reset** (rst=0 at posedge): all registered fields become 0, so aluc=0 (ALU outputs 0), rd=0 and all controls are 0. With rs/rt addr=0 no forwarding occurs, so alu_data1 = alu_data2 = ex_store_data = 0. Reset wins over flush and stall; reset mid-stall discards the held instruction.
- **Register update per posedge**, highest priority first:
  - rst=0 → reset.
  - flush=1 → bubble.
  - load_use_stall=1 → bubble.
  - Otherwise → capture the ID fields.
- **Bubble:** aluc=0, rd=0, all controls 0. Operand fields may be anything, but are zeroed.
- **Immediate extension at capture**, stored as 32-bit ex_imm:
  - aluc 10/14/15: sign-extend.
  - aluc 11/12/13: zero-extend.
  - aluc 18: zero-extend; the ALU performs the <<16.
  - Other codes: 0.
- **Operand usage:**
  - rs is used for aluc 1-5 and 10-15.
  - rt is used for aluc 1-8 and 15.
  - Unused registers never trigger stalls.
- **Load-use detect** (combinational): stall=1 when all of the following hold:
  - ex_mem_read=1 and ex_rd≠0;
  - ex_rd equals id_rs_addr (rs used) or id_rt_addr (rt used), per the ID-side aluc.
- **Stall sequencing:** the stall lasts exactly one cycle, because the next cycle holds a bubble in EX. flush=1 in the same cycle takes priority, but stall is still asserted (harmless).
- **Forwarding** (EX stage, per source reg r = ex_rs_addr or ex_rt_addr):
  - r=0 → captured value.
  - Else exm_reg_write=1 && exm_rd==r → exm_result.
  - Else mwb_reg_write=1 && mwb_rd==r → mwb_result.
  - Else the captured value. EX/MEM always beats MEM/WB.
- **ALU operand mux:**
  - alu_data1 = {27'b0, ex_shamt} for aluc 6/7/8; otherwise fwd_rs.
  - alu_data2 = ex_imm for aluc 10-15 and 18; otherwise fwd_rt.
  - ex_store_data = fwd_rt always.
- **Latency:** ID fields appear at EX outputs 1 cycle after capture. Forwarding adds no cycles.
- **Register-file scope:** a same-cycle WB write/ID read conflict is the register file's responsibility, not this block's.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (ALU_NOP=0 … ALU_LUI=18);
  - use_rs(), use_rt(), is_shift(), is_imm() and imm-extension-kind helpers;
  - DATA_W/REG_AW defaults.
- One sub-module, fwd_unit: purely combinational forwarding select for one operand. It is instantiated twice (rs, rt).

Test Plan:
- Reset: drive rst=0 with random ID inputs for 2 cycles → all outputs 0, load_use_stall=0.
- EX/MEM priority: add $3=$1+$2 with exm_rd=1, exm_result=0x10 and mwb_rd=1, mwb_result=0x20, both writes enabled → alu_data1=0x10.
- Forwarding to r0 blocked: exm_rd=0 write-enabled with result 0xFFFF → no forward on rs=0; alu_data1=captured 0.
- Load-use: lw into $5 in EX, then ID add using $5 → stall=1 for one cycle, next EX aluc=0/rd=0. After that the add enters with mwb_rd=5, mwb_result=0xABCD → alu_data2=0xABCD.
- Immediate/shift: addi imm16=0xFFFF → data2=0xFFFFFFFF; ori 0xFFFF → 0x0000FFFF; sll shamt=4 → data1=4, data2=fwd rt. No stall for lui after lw to rs.
- Flush with stall: flush=1 with ID lw and a load-use condition → EX bubble next cycle; reset mid-stall → all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes, default widths and
// decode helpers. The ID side uses them for hazard detection and the EX side
// uses them for operand selection.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_ADDI = 5'd10;
  localparam logic [4:0] ALU_ANDI = 5'd11;
  localparam logic [4:0] ALU_ORI  = 5'd12;
  localparam logic [4:0] ALU_XORI = 5'd13;
  localparam logic [4:0] ALU_LW   = 5'd14;
  localparam logic [4:0] ALU_SW   = 5'd15;
  localparam logic [4:0] ALU_LUI  = 5'd18;

  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_SIGN,
    EXT_ZERO
  } imm_ext_e;

  // rs is read by register ALU ops and by every immediate op except lui
  function automatic logic use_rs(input logic [4:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_ADDI, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LW, ALU_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rt is a true source for register ALU ops, shifts, and as store data
  function automatic logic use_rt(input logic [4:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // ops whose second ALU operand is the extended immediate
  function automatic logic is_imm(input logic [4:0] op);
    case (op)
      ALU_ADDI, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LW, ALU_SW, ALU_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // lui is zero-extended here; the ALU itself applies the <<16
  function automatic imm_ext_e imm_ext_kind(input logic [4:0] op);
    case (op)
      ALU_ADDI, ALU_LW, ALU_SW:           return EXT_SIGN;
      ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LUI: return EXT_ZERO;
      default:                            return EXT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle between the pipeline around the ID/EX stage and the stage itself:
// decoded ID fields, EX/MEM and MEM/WB forwarding sources, and EX outputs.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
);

  logic              flush;
  logic [4:0]        id_aluc;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [15:0]       id_imm16;
  logic [4:0]        id_shamt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;

  logic [REG_AW-1:0] exm_rd;
  logic              exm_reg_write;
  logic [DATA_W-1:0] exm_result;
  logic [REG_AW-1:0] mwb_rd;
  logic              mwb_reg_write;
  logic [DATA_W-1:0] mwb_result;

  logic              load_use_stall;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [4:0]        alu_aluc;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output flush, id_aluc, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_val, id_rt_val,
           id_imm16, id_shamt, id_reg_write, id_mem_read, id_mem_write,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
    input  load_use_stall, alu_data1, alu_data2, alu_aluc, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  flush, id_aluc, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_val, id_rt_val,
           id_imm16, id_shamt, id_reg_write, id_mem_read, id_mem_write,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
    output load_use_stall, alu_data1, alu_data2, alu_aluc, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding select for one EX source operand. EX/MEM is the younger result,
// so it beats MEM/WB; register 0 is never forwarded.
module fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_val,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] fwd_val
);

  // pick the newest in-flight value for src_addr, falling back to the captured read
  always_comb begin
    fwd_val = src_val;
    if (src_addr != '0) begin
      if (exm_reg_write && (exm_rd == src_addr)) begin
        fwd_val = exm_result;
      end else if (mwb_reg_write && (mwb_rd == src_addr)) begin
        fwd_val = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand builder. Captures decoded fields,
// detects load-use hazards against the instruction in EX, and builds the ALU
// operands with forwarding from EX/MEM and MEM/WB.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic [4:0]        ex_aluc;
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [REG_AW-1:0] ex_rd_q;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_shamt;
  logic              ex_reg_write_q;
  logic              ex_mem_read_q;
  logic              ex_mem_write_q;

  logic              stall;
  logic [DATA_W-1:0] id_imm_ext;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // a load in EX whose destination is a real source of the ID instruction must wait one cycle
  always_comb begin
    stall = 1'b0;
    if (ex_mem_read_q && (ex_rd_q != '0)) begin
      if (use_rs(bus.id_aluc) && (ex_rd_q == bus.id_rs_addr)) stall = 1'b1;
      if (use_rt(bus.id_aluc) && (ex_rd_q == bus.id_rt_addr)) stall = 1'b1;
    end
  end

  // extend the immediate at capture so EX only has to select it
  always_comb begin
    id_imm_ext = '0;
    case (imm_ext_kind(bus.id_aluc))
      EXT_SIGN: id_imm_ext = {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16};
      EXT_ZERO: id_imm_ext = {{(DATA_W-16){1'b0}}, bus.id_imm16};
      default:  id_imm_ext = '0;
    endcase
  end

  // reset, flush and stall all leave a fully zeroed bubble in EX; otherwise capture ID
  always_ff @(posedge clk) begin
    if (!rst || bus.flush || stall) begin
      ex_aluc        <= ALU_NOP;
      ex_rs_addr     <= '0;
      ex_rt_addr     <= '0;
      ex_rd_q        <= '0;
      ex_rs_val      <= '0;
      ex_rt_val      <= '0;
      ex_imm         <= '0;
      ex_shamt       <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
    end else begin
      ex_aluc        <= bus.id_aluc;
      ex_rs_addr     <= bus.id_rs_addr;
      ex_rt_addr     <= bus.id_rt_addr;
      ex_rd_q        <= bus.id_rd_addr;
      ex_rs_val      <= bus.id_rs_val;
      ex_rt_val      <= bus.id_rt_val;
      ex_imm         <= id_imm_ext;
      ex_shamt       <= bus.id_shamt;
      ex_reg_write_q <= bus.id_reg_write;
      ex_mem_read_q  <= bus.id_mem_read;
      ex_mem_write_q <= bus.id_mem_write;
    end
  end

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr      (ex_rs_addr),
    .src_val       (ex_rs_val),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .fwd_val       (fwd_rs)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr      (ex_rt_addr),
    .src_val       (ex_rt_val),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .fwd_val       (fwd_rt)
  );

  // shifts take shamt as operand 1; immediate ops take the extended immediate as operand 2
  always_comb begin
    bus.alu_data1 = fwd_rs;
    bus.alu_data2 = fwd_rt;
    if (is_shift(ex_aluc)) bus.alu_data1 = {{(DATA_W-5){1'b0}}, ex_shamt};
    if (is_imm(ex_aluc))   bus.alu_data2 = ex_imm;
  end

  assign bus.load_use_stall = stall;
  assign bus.alu_aluc       = ex_aluc;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ex_rd          = ex_rd_q;
  assign bus.ex_reg_write   = ex_reg_write_q;
  assign bus.ex_mem_read    = ex_mem_read_q;
  assign bus.ex_mem_write   = ex_mem_write_q;

endmodule
